// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared stall vectors, sequencer states and exception codes
//               for the pipeline stall/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // Hold bits: [0]=pc, [1]=if_id, [2]=id_ex, [3]=ex_mem, [4]=mem_wb, [5]=wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MCYC = 2'd1,
        ST_FLSH = 2'd2
    } state_e;

    localparam logic [31:0] EXC_ERET           = 32'h0000_000E;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    // Deepest requesting stage wins; each vector is a superset of the next.
    function automatic logic [5:0] stall_merge(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [5:0] v;
        v = STALL_NONE;
        if (req_mem)     v = STALL_MEM;
        else if (req_ex) v = STALL_EX;
        else if (req_id) v = STALL_ID;
        else if (req_if) v = STALL_IF;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_mc_counter.sv
`default_nettype none
// ============================================================================
// Module      : mc_counter
// Description : Loadable down-counter with zero flag; stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline: merges stall
//               requests, owns multi-cycle EX hold windows, issues flushes.
//               Optional stall watchdog enabled by defining STALL_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          MC_LEN_W   = 6,
    parameter int          WDT_LIMIT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    input  logic                exc_valid,
    input  logic [31:0]         excepttype,
    input  logic [31:0]         cp0_epc,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                mc_busy,
    output logic                mc_done,
    output logic                mc_abort,
    output logic                wdt_timeout
);

    state_e              state_q, state_d;
    logic                flush_q, flush_d;
    logic [31:0]         new_pc_q, new_pc_d;
    logic                abort_q, abort_d;

    logic                w_cnt_clr;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic [MC_LEN_W-1:0] w_cnt_load_val;
    logic [MC_LEN_W-1:0] w_count;
    logic                w_cnt_zero;

    logic                w_mc_hold;
    logic                w_wdt_trip;
    logic                w_exc;
    logic [31:0]         w_redirect;

    mc_counter #(
        .W (MC_LEN_W)
    ) u_mc_counter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (w_cnt_clr),
        .load_i     (w_cnt_load),
        .load_val_i (w_cnt_load_val),
        .dec_i      (w_cnt_dec),
        .count_o    (w_count),
        .zero_o     (w_cnt_zero)
    );

    // A zero length behaves as a one-cycle operation.
    assign w_cnt_load_val = (ex_mc_len == '0) ? '0 : (ex_mc_len - 1'b1);

    assign w_mc_hold = ((state_q == ST_RUN)  && ex_mc_start) ||
                       ((state_q == ST_MCYC) && !w_cnt_zero);

    assign w_exc      = exc_valid || w_wdt_trip;
    assign w_redirect = (exc_valid && !w_wdt_trip && (excepttype == EXC_ERET))
                        ? cp0_epc : EXC_VECTOR;

    always_comb begin
        stall = STALL_NONE;
        if (!rst && (state_q != ST_FLSH)) begin
            stall = stall_merge(stallreq_if, stallreq_id,
                                stallreq_ex || w_mc_hold, stallreq_mem);
        end
    end

    always_comb begin
        state_d    = state_q;
        flush_d    = 1'b0;
        new_pc_d   = new_pc_q;
        abort_d    = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (w_exc) begin
                    state_d  = ST_FLSH;
                    flush_d  = 1'b1;
                    new_pc_d = w_redirect;
                end else if (ex_mc_start) begin
                    state_d    = ST_MCYC;
                    w_cnt_load = 1'b1;
                end
            end
            ST_MCYC: begin
                if (w_exc) begin
                    state_d   = ST_FLSH;
                    flush_d   = 1'b1;
                    new_pc_d  = w_redirect;
                    abort_d   = 1'b1;
                    w_cnt_clr = 1'b1;
                end else if (w_cnt_zero) begin
                    state_d = ST_RUN;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_FLSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_RUN;
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0000_0000;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            abort_q  <= abort_d;
        end
    end

    // Done marks the drain cycle right after the final hold cycle.
    assign mc_busy  = !rst && (state_q == ST_MCYC) && !w_cnt_zero;
    assign mc_done  = !rst && (state_q == ST_MCYC) && w_cnt_zero && !w_exc;
    assign flush    = flush_q;
    assign new_pc   = new_pc_q;
    assign mc_abort = abort_q;

`ifdef STALL_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_LIMIT + 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_flag_q;

    assign w_wdt_trip = (state_q != ST_FLSH) && (stall != STALL_NONE) &&
                        (wdt_cnt_q == WDT_W'(WDT_LIMIT - 1));

    always_comb begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
        if ((stall == STALL_NONE) || flush_q || w_wdt_trip) begin
            wdt_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_q  <= '0;
            wdt_flag_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            if (w_wdt_trip) begin
                wdt_flag_q <= 1'b1;
            end
        end
    end

    assign wdt_timeout = wdt_flag_q;
`else
    logic w_unused_wdt;
    assign w_unused_wdt = (WDT_LIMIT == 0) ^ (|w_count);
    assign w_wdt_trip   = 1'b0;
    assign wdt_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Scoreboard bench for pipeline_ctrl; per-cycle expectations
//               are queued at drive time and compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int MC_LEN_W = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic                ex_mc_start;
    logic [MC_LEN_W-1:0] ex_mc_len;
    logic                exc_valid;
    logic [31:0]         excepttype;
    logic [31:0]         cp0_epc;
    logic [5:0]          stall;
    logic                flush;
    logic [31:0]         new_pc;
    logic                mc_busy, mc_done, mc_abort, wdt_timeout;

    typedef struct {
        string       tag;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        chk_pc;
        logic        busy;
        logic        done;
        logic        abort;
        logic        wdt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_wdt  = 1'b0;

    pipeline_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .MC_LEN_W   (MC_LEN_W),
        .WDT_LIMIT  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_len    (ex_mc_len),
        .exc_valid    (exc_valid),
        .excepttype   (excepttype),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .mc_abort     (mc_abort),
        .wdt_timeout  (wdt_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val({e.tag, ".stall"}, {26'b0, stall}, {26'b0, e.stall});
            check_val({e.tag, ".flush"}, {31'b0, flush}, {31'b0, e.flush});
            check_val({e.tag, ".busy"},  {31'b0, mc_busy}, {31'b0, e.busy});
            check_val({e.tag, ".done"},  {31'b0, mc_done}, {31'b0, e.done});
            check_val({e.tag, ".abort"}, {31'b0, mc_abort}, {31'b0, e.abort});
            check_val({e.tag, ".wdt"},   {31'b0, wdt_timeout}, {31'b0, e.wdt});
            if (e.chk_pc) begin
                check_val({e.tag, ".new_pc"}, new_pc, e.pc);
            end
        end
    end

    // Advance to just after the next rising edge, then apply inputs.
    task automatic drive(input logic r, input logic [3:0] req_mem_ex_id_if,
                         input logic st, input int len, input logic ev,
                         input logic [31:0] et, input logic [31:0] epc);
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_mem = req_mem_ex_id_if[3];
        stallreq_ex  = req_mem_ex_id_if[2];
        stallreq_id  = req_mem_ex_id_if[1];
        stallreq_if  = req_mem_ex_id_if[0];
        ex_mc_start  = st;
        ex_mc_len    = MC_LEN_W'(len);
        exc_valid    = ev;
        excepttype   = et;
        cp0_epc      = epc;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] s,
                              input logic f, input logic [31:0] pc,
                              input logic cpc, input logic b,
                              input logic d, input logic a);
        exp_t e;
        e.tag = tag; e.stall = s; e.flush = f; e.pc = pc; e.chk_pc = cpc;
        e.busy = b; e.done = d; e.abort = a; e.wdt = exp_wdt;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0;
        ex_mc_start = 1'b0; ex_mc_len = '0; exc_valid = 1'b0;
        excepttype = 32'h0; cp0_epc = 32'h0;

        // Reset: outputs cleared and stall suppressed despite requests
        drive(1, 4'b1010, 0, 0, 0, 0, 0);     expect_out("rst0", 6'b000000, 0, 32'h0, 1, 0, 0, 0);
        drive(1, 4'b0000, 1, 4, 0, 0, 0);     expect_out("rst1", 6'b000000, 0, 32'h0, 1, 0, 0, 0);

        // Stall priority
        drive(0, 4'b1010, 0, 0, 0, 0, 0);     expect_out("memid", 6'b011111, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0010, 0, 0, 0, 0, 0);     expect_out("id",    6'b000111, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0101, 0, 0, 0, 0, 0);     expect_out("exif",  6'b001111, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0001, 0, 0, 0, 0, 0);     expect_out("if",    6'b000011, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("none",  6'b000000, 0, 0, 0, 0, 0, 0);

        // len=4: four hold cycles, busy for three, done on the fifth
        drive(0, 4'b0000, 1, 4, 0, 0, 0);     expect_out("l4c1", 6'b001111, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("l4c2", 6'b001111, 0, 0, 0, 1, 0, 0);
        drive(0, 4'b0000, 1, 8, 0, 0, 0);     expect_out("l4c3", 6'b001111, 0, 0, 0, 1, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("l4c4", 6'b001111, 0, 0, 0, 1, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("l4c5", 6'b000000, 0, 0, 0, 0, 1, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("l4c6", 6'b000000, 0, 0, 0, 0, 0, 0);

        // len=0 acts as len=1
        drive(0, 4'b0000, 1, 0, 0, 0, 0);     expect_out("l0c1", 6'b001111, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("l0c2", 6'b000000, 0, 0, 0, 0, 1, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("l0c3", 6'b000000, 0, 0, 0, 0, 0, 0);

        // Exception kills a len=8 window; flush beats requests, FLSH ignores exc/start
        drive(0, 4'b0000, 1, 8, 0, 0, 0);     expect_out("ab1", 6'b001111, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("ab2", 6'b001111, 0, 0, 0, 1, 0, 0);
        drive(0, 4'b0000, 0, 0, 1, 32'hC, 0); expect_out("ab3", 6'b001111, 0, 0, 0, 1, 0, 0);
        drive(0, 4'b1000, 1, 3, 1, 32'hC, 0); expect_out("ab4", 6'b000000, 1, 32'h20, 1, 0, 0, 1);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("ab5", 6'b000000, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("ab6", 6'b000000, 0, 0, 0, 0, 0, 0);

        // ERET returns to EPC
        drive(0, 4'b0001, 0, 0, 1, 32'hE, 32'h0040_1000); expect_out("er1", 6'b000011, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0001, 0, 0, 0, 0, 0);     expect_out("er2", 6'b000000, 1, 32'h0040_1000, 1, 0, 0, 0);
        drive(0, 4'b0001, 0, 0, 0, 0, 0);     expect_out("er3", 6'b000011, 0, 0, 0, 0, 0, 0);

        // Exception in RUN overrides a simultaneous start
        drive(0, 4'b0000, 1, 5, 1, 32'h0, 32'h1234); expect_out("xo1", 6'b001111, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("xo2", 6'b000000, 1, 32'h20, 1, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("xo3", 6'b000000, 0, 0, 0, 0, 0, 0);

        // Reset mid-MCYC: no done or abort afterwards
        drive(0, 4'b0000, 1, 6, 0, 0, 0);     expect_out("rm1", 6'b001111, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("rm2", 6'b001111, 0, 0, 0, 1, 0, 0);
        drive(1, 4'b0000, 0, 0, 0, 0, 0);     expect_out("rm3", 6'b000000, 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("rm4", 6'b000000, 0, 32'h0, 1, 0, 0, 0);

        // Reset mid-FLSH
        drive(0, 4'b0000, 0, 0, 1, 32'hC, 0); expect_out("rf1", 6'b000000, 0, 0, 0, 0, 0, 0);
        drive(1, 4'b0000, 0, 0, 0, 0, 0);     expect_out("rf2", 6'b000000, 1, 32'h20, 1, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("rf3", 6'b000000, 0, 32'h0, 1, 0, 0, 0);

`ifdef STALL_WATCHDOG_EN
        // Sixteen stalled cycles trip the watchdog; flush follows
        for (int i = 1; i <= 16; i++) begin
            drive(0, 4'b0001, 0, 0, 0, 0, 0); expect_out($sformatf("wd%0d", i), 6'b000011, 0, 0, 0, 0, 0, 0);
        end
        exp_wdt = 1'b1;
        drive(0, 4'b0001, 0, 0, 0, 0, 0);     expect_out("wd17", 6'b000000, 1, 32'h20, 1, 0, 0, 0);
        for (int i = 18; i <= 20; i++) begin
            drive(0, 4'b0001, 0, 0, 0, 0, 0); expect_out($sformatf("wd%0d", i), 6'b000011, 0, 0, 0, 0, 0, 0);
        end
        exp_wdt = 1'b0;
        drive(1, 4'b0000, 0, 0, 0, 0, 0);     expect_out("wdrst", 6'b000000, 0, 32'h0, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0, 0);     expect_out("wdclr", 6'b000000, 0, 32'h0, 1, 0, 0, 0);
`endif

        repeat (2) @(posedge clk);
        check_val("drain", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
